// File: rtl/debounce_tx.sv
// debounce_tx
//   Transmit-side counterpart to the input debouncers. Level requests arrive
//   over a valid/ready handshake, are queued in a small FIFO and driven onto
//   a single registered output line. Every driven level is held for at least
//   MIN_HOLD cycles, so a remote debouncer with a smaller threshold sees every
//   requested level.
//
// Parameters
//   MIN_HOLD    minimum cycles each driven level is held (>= 1)
//   DEPTH       request FIFO entries (power of 2, >= 2)
//   RESET_LEVEL value of o during and after reset
//   W_CTR       hold counter width (leave at default)
//   W_FILL      fill output width (leave at default)
//
// Ports
//   clk        clock
//   rst_n      asynchronous, active-low reset
//   req_valid  a level request is presented
//   req_ready  request can be accepted (transfer on valid && ready)
//   req_level  requested output level
//   flush      synchronous discard of all queued, not yet driven requests
//   o          driven output line (registered)
//   busy       hold in progress or FIFO non-empty
//   fill       number of queued requests, 0..DEPTH
//
// Configuration
//   DEBOUNCE_TX_MERGE_EN  when defined, an accepted request whose level equals
//                         the reference level (last queued level, or o when
//                         the FIFO is empty) is consumed without being queued.

module debounce_tx #(
    parameter int   MIN_HOLD    = 128,
    parameter int   DEPTH       = 4,
    parameter logic RESET_LEVEL = 1'b0,
    parameter int   W_CTR       = $clog2(MIN_HOLD + 1),
    parameter int   W_FILL      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_level,
    input  logic              flush,
    output logic              o,
    output logic              busy,
    output logic [W_FILL-1:0] fill
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [W_CTR-1:0] ctr;
    logic [W_CTR-1:0] ctr_next;
    logic             o_next;
    logic             pop;
    logic             push;
    logic             accept;
    logic             hold_done;
    logic             fifo_empty;
    logic             fifo_full;
    logic             head_level;

    logic             mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign fifo_empty = (fill == '0);
    assign fifo_full  = (fill == W_FILL'(DEPTH));
    assign head_level = mem[rd_ptr];

    // No bypass path: a full FIFO refuses even if a pop frees a slot this cycle.
    assign req_ready  = !fifo_full && !flush;
    assign accept     = req_valid && req_ready;

    assign hold_done  = (state == HOLD) && (ctr == W_CTR'(MIN_HOLD - 1));
    assign busy       = (state == HOLD) || !fifo_empty;

`ifdef DEBOUNCE_TX_MERGE_EN
    logic [AW-1:0] last_idx;
    logic          ref_level;
    logic          merge;

    // Compare against what o will eventually settle to before the new request:
    // the newest queued level, or the line itself when nothing is queued.
    assign last_idx  = wr_ptr - AW'(1);
    assign ref_level = fifo_empty ? o : mem[last_idx];
    assign merge     = accept && (req_level == ref_level);
    assign push      = accept && !merge;
`else
    assign push      = accept;
`endif

    // State, hold counter and output line registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ctr   <= '0;
            o     <= RESET_LEVEL;
        end else begin
            state <= state_next;
            ctr   <= ctr_next;
            o     <= o_next;
        end
    end

    // Next-state logic. Every pop restarts a full hold, even if the popped
    // level equals the current line value.
    always_comb begin
        state_next = state;
        ctr_next   = ctr;
        o_next     = o;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                ctr_next = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    o_next     = head_level;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (hold_done) begin
                    ctr_next = '0;
                    if (!fifo_empty) begin
                        pop    = 1'b1;
                        o_next = head_level;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    ctr_next = ctr + W_CTR'(1);
                end
            end
            default: begin
                state_next = IDLE;
                ctr_next   = '0;
            end
        endcase
    end

    // FIFO storage; contents need no reset because fill gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= req_level;
        end
    end

    // FIFO pointers and fill. Flush empties the queue by snapping the read
    // pointer to the write pointer; a pop in the same cycle has already
    // sampled the head, so it still drives o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (flush) begin
                rd_ptr <= wr_ptr;
                fill   <= '0;
            end else begin
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({push, pop})
                    2'b10:   fill <= fill + W_FILL'(1);
                    2'b01:   fill <= fill - W_FILL'(1);
                    default: fill <= fill;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_debounce_tx.sv
// tb_debounce_tx
//   Self-checking bench for debounce_tx with MIN_HOLD=8, DEPTH=4. A reference
//   model keeps the queued levels in a queue and the remaining hold time as a
//   plain count of cycles; every edge the DUT's o, busy, fill and req_ready
//   are compared against it. Directed sequences cover the documented timing
//   cases, followed by a randomized run with occasional flushes and resets.

module tb_debounce_tx;

    localparam int   MIN_HOLD    = 8;
    localparam int   DEPTH       = 4;
    localparam logic RESET_LEVEL = 1'b0;
    localparam int   W_FILL      = $clog2(DEPTH + 1);

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_level;
    logic              flush;
    logic              o;
    logic              busy;
    logic [W_FILL-1:0] fill;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit m_o;
    bit m_q[$];
    int m_hold_left;

    // Per-edge history for the directed timing checks
    logic o_hist    [64];
    logic busy_hist [64];
    int   edge_idx;
    bit   record_en;

    debounce_tx #(
        .MIN_HOLD    (MIN_HOLD),
        .DEPTH       (DEPTH),
        .RESET_LEVEL (RESET_LEVEL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_level (req_level),
        .flush     (flush),
        .o         (o),
        .busy      (busy),
        .fill      (fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_o         = RESET_LEVEL;
        m_q.delete();
        m_hold_left = 0;
    endtask

    function automatic bit modelReady(input bit fl);
        return (m_q.size() != DEPTH) && !fl;
    endfunction

    // One clock edge of the reference model, from the spec's rules:
    // a level leaves the queue when the line is free (no hold, or the last
    // hold cycle), and each departure buys it MIN_HOLD cycles on the line.
    task automatic modelEdge(input bit v, input bit lvl, input bit fl);
        bit acc;
        bit merged;
        acc    = v && modelReady(fl);
        merged = 1'b0;
`ifdef DEBOUNCE_TX_MERGE_EN
        if (acc) merged = (lvl == ((m_q.size() != 0) ? m_q[$] : m_o));
`endif
        if (m_hold_left <= 1 && m_q.size() > 0) begin
            m_o         = m_q.pop_front();
            m_hold_left = MIN_HOLD;
        end else if (m_hold_left > 0) begin
            m_hold_left--;
        end
        if (fl) m_q.delete();
        if (acc && !merged) m_q.push_back(lvl);
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, ".o"},    32'(o),    32'(m_o));
        checkOutput({tag, ".busy"}, 32'(busy), 32'((m_hold_left > 0) || (m_q.size() > 0)));
        checkOutput({tag, ".fill"}, 32'(fill), 32'(m_q.size()));
    endtask

    // Drive one cycle of inputs at the falling edge, check ready before the
    // rising edge and the registered outputs just after it.
    task automatic applyStimulus(input bit v, input bit lvl, input bit fl);
        @(negedge clk);
        req_valid = v;
        req_level = lvl;
        flush     = fl;
        #1;
        checkOutput("req_ready", 32'(req_ready), 32'(modelReady(fl)));
        @(posedge clk);
        #1;
        modelEdge(v, lvl, fl);
        checkState("edge");
        if (record_en && edge_idx < 64) begin
            o_hist[edge_idx]    = o;
            busy_hist[edge_idx] = busy;
        end
        edge_idx++;
    endtask

    // Reset asserted between edges; o must return to the reset level at once.
    task automatic applyReset();
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst.o",    32'(o),    32'(RESET_LEVEL));
        checkOutput("rst.fill", 32'(fill), 32'd0);
        checkOutput("rst.busy", 32'(busy), 32'd0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int vprob;
        bit v;
        bit fl;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_level = 1'b0;
        flush     = 1'b0;
        record_en = 1'b0;
        edge_idx  = 0;
        modelReset();

        // Reset release, nothing requested
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("init.o",         32'(o),         32'd0);
        checkOutput("init.busy",      32'(busy),      32'd0);
        checkOutput("init.fill",      32'(fill),      32'd0);
        checkOutput("init.req_ready", 32'(req_ready), 32'd1);

        // Back-to-back 1,0,1 from idle: o changes at E1, E9, E17; busy drops at E25
        edge_idx  = 0;
        record_en = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (28) applyStimulus(1'b0, 1'b0, 1'b0);
        record_en = 1'b0;
        checkOutput("seq.o@E0",     32'(o_hist[0]),     32'd0);
        checkOutput("seq.o@E1",     32'(o_hist[1]),     32'd1);
        checkOutput("seq.o@E8",     32'(o_hist[8]),     32'd1);
        checkOutput("seq.o@E9",     32'(o_hist[9]),     32'd0);
        checkOutput("seq.o@E16",    32'(o_hist[16]),    32'd0);
        checkOutput("seq.o@E17",    32'(o_hist[17]),    32'd1);
        checkOutput("seq.busy@E24", 32'(busy_hist[24]), 32'd1);
        checkOutput("seq.busy@E25", 32'(busy_hist[25]), 32'd0);

        // Overfill while a hold is active: ready drops at fill=DEPTH
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, i[0], 1'b0);
        checkOutput("full.fill",  32'(fill),      32'(DEPTH));
        checkOutput("full.ready", 32'(req_ready), 32'd0);
        repeat (50) applyStimulus(1'b0, 1'b0, 1'b0);

        // Flush with three queued behind an o=1 hold
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("flush.fill", 32'(fill), 32'd0);
        checkOutput("flush.o",    32'(o),    32'd1);
        repeat (12) applyStimulus(1'b0, 1'b0, 1'b0);

        // Request equal to the idle line level
        applyStimulus(1'b1, 1'b1, 1'b0);
`ifdef DEBOUNCE_TX_MERGE_EN
        checkOutput("same.busy", 32'(busy), 32'd0);
`else
        checkOutput("same.busy", 32'(busy), 32'd1);
`endif
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0);

        // Reset mid-hold with o=1 and two queued, then first push after release
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("pre_rst.o",    32'(o),    32'd1);
        checkOutput("pre_rst.fill", 32'(fill), 32'd2);
        applyReset();
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("post_rst.o@E0", 32'(o), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("post_rst.o@E1", 32'(o), 32'd1);
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0);

        // Randomized traffic with phases of light, medium and heavy load
        vprob = 50;
        for (int i = 0; i < 2000; i++) begin
            if (i % 100 == 0) begin
                case ($urandom_range(0, 2))
                    0:       vprob = 10;
                    1:       vprob = 50;
                    default: vprob = 95;
                endcase
            end
            if ($urandom_range(0, 599) == 0) begin
                applyReset();
            end
            v  = ($urandom_range(0, 99) < vprob);
            fl = ($urandom_range(0, 29) == 0);
            applyStimulus(v, 1'($urandom_range(0, 1)), fl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
